div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for the MIPS datapath, serving DIV and DIVU in the execute stage.
- It is the responder end of the divide-stall handshake. The hazard unit holds E stalled while a divide is in E and div_ready is low. This block raises div_ready for exactly one cycle when the quotient and remainder are valid.
- Results feed the HI/LO write path: HI = remainder, LO = quotient.

Parameters:
- WIDTH, 32, operand width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  divide requested; high while a DIV/DIVU control sits in E.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- annul  input  1  abort the current operation (E flushed, or exception).
- opa  input  WIDTH  dividend; sampled when start is accepted.
- opb  input  WIDTH  divisor; sampled when start is accepted.
- div_ready  output  1  result valid, one-cycle pulse.
- result  output  2*WIDTH  {remainder, quotient}.

Behaviour:
- Reset (resetn=0, async): state=IDLE, div_ready=0, result=0, counter=0, internal regs=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and annul=0 at an edge: latch operands.
  - If signed_div=1, take absolute values, and record sign_q = opa[31]^opb[31] and sign_r = opa[31].
  - Clear partial remainder, set counter=0, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Each edge performs one restoring step: shift {rem, quo} left 1; trial-subtract the divisor from the upper half; if non-negative, keep the difference and set quo[0]=1.
  - Counter increments each step. After the WIDTH-th step (counter == WIDTH-1 at the edge), go to DONE.
  - On that same edge, load result with sign-fixed values: quotient negated if sign_q; remainder negated if sign_r. Both are unadjusted for DIVU.
- DONE:
  - div_ready=1 for this single cycle, then go to IDLE unconditionally.
  - start being high in DONE is not a new request. The stalled instruction leaves E on this edge.
- div_ready is registered, equal to (state==DONE). It is never high two consecutive cycles for one operation.
- Latency: div_ready is high in the cycle 1+WIDTH+0 edges after acceptance, i.e. 33 cycles after the start-accept edge for WIDTH=32. Back-to-back divides: the next start is accepted in the cycle after DONE.
- result holds its last value until the next BUSY→DONE edge. It is unchanged by annul and by new starts.
- start while BUSY or DONE: ignored.
- annul:
  - Any state → IDLE at the next edge; div_ready=0 next cycle; result unchanged.
  - annul and start in the same IDLE cycle: annul wins, no operation starts.
  - annul in DONE: the pulse already asserted in that cycle still stands; the state goes to IDLE.
- Divide by zero (no trap, defined result): quotient = all-ones, remainder = dividend (raw, before sign fix). Signed divide by zero returns the same values with no sign adjustment.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Reset mid-operation: immediate return to the reset state.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined:
  - IDLE accepting start with opb==0 goes directly to DONE with result = {opa, all-ones}.
  - div_ready is high the cycle after acceptance (latency 1).
- Undefined:
  - Divide by zero runs the full WIDTH iterations and produces the same values at full latency.

Test Plan:
- DIVU 100/7: start with signed_div=0 → div_ready exactly 33 cycles after acceptance, one cycle wide; result={32'd2, 32'd14}.
- DIV -100/7 (0xFFFFFF9C / 7) → quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2). DIV 100/-7 → quotient -14, remainder 2.
- DIV 0x80000000 / 0xFFFFFFFF → result={0, 0x80000000}. DIVU 5/0 → {5, 0xFFFFFFFF}.
  - Latency is 33 without DIV_ZERO_FAST_EN and 1 with it.
- Accept 50/5, then pulse annul at cycle 10 → no div_ready; state IDLE; result keeps the prior value.
  - Then start 9/2 → {1, 4} after 33 cycles.
- Back-to-back: start held high through DONE, opa/opb changed to 81/9 the cycle after div_ready → exactly one pulse for the first operation; the second pulse comes 33 cycles later with {0, 9}.
- Drop resetn at cycle 15 of a divide → div_ready=0 and result=0 immediately (asynchronous), without waiting for a clock edge.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result = {remainder, quotient}.
// Optional DIV_ZERO_FAST_EN: divide by zero finishes one cycle after acceptance.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic               div_ready,
    output logic [2*WIDTH-1:0] result
);

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic               accept;
    logic               zero_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     diff;
    logic               step_ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quo_fix;

    assign accept = (state_q == IDLE) && start && !annul;
    assign zero_b = (opb == '0);
    assign abs_a  = (signed_div && opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
    assign abs_b  = (signed_div && opb[WIDTH-1]) ? (~opb + 1'b1) : opb;

    // One restoring step: partial remainder stays below the divisor, so WIDTH+1 bits suffice.
    assign shl      = {rem_q, quo_q[WIDTH-1]};
    assign diff     = shl - {1'b0, dvs_q};
    assign step_ge  = !diff[WIDTH];
    assign rem_step = step_ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], step_ge};

    // Divide by zero keeps the all-ones quotient; the remainder fix restores the raw dividend.
    assign quo_fix = (qneg_q && !dz_q) ? (~quo_step + 1'b1) : quo_step;
    assign rem_fix = rneg_q ? (~rem_step + 1'b1) : rem_step;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (FAST_ZERO && zero_b) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (annul) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        result_d = result_q;
        ready_d  = (state_d == DONE);
        if (accept) begin
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = abs_a;
            dvs_d  = abs_b;
            qneg_d = signed_div && (opa[WIDTH-1] ^ opb[WIDTH-1]);
            rneg_d = signed_div && opa[WIDTH-1];
            dz_d   = zero_b;
            if (FAST_ZERO && zero_b) begin
                result_d = {opa, {WIDTH{1'b1}}};
            end
        end
        if (state_q == BUSY && !annul) begin
            cnt_d = cnt_q + 1'b1;
            rem_d = rem_step;
            quo_d = quo_step;
            if (cnt_q == LAST) begin
                result_d = {rem_fix, quo_fix};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign div_ready = ready_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor pops on div_ready.
// Zero-divisor latency follows DIV_ZERO_FAST_EN.
module tb_div_unit;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        div_ready;
    logic [63:0] result;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .opa        (opa),
        .opb        (opb),
        .div_ready  (div_ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          at;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          npulse = 0;
    bit          last_rdy = 1'b0;
    logic [63:0] last_res = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            last_rdy = 1'b0;
        end else begin
            if (div_ready) begin
                npulse++;
                checks++;
                if (last_rdy) begin
                    errors++;
                    $display("FAIL pulse_width: div_ready high again at cyc %0d, required one cycle", cyc);
                end
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: result %h at cyc %0d, required no pulse", result, cyc);
                end else begin
                    mon_e = q.pop_front();
                    checks += 2;
                    if (result !== mon_e.res) begin
                        errors++;
                        $display("FAIL %s result: got %h required %h", mon_e.name, result, mon_e.res);
                    end
                    if (cyc != mon_e.at) begin
                        errors++;
                        $display("FAIL %s latency: pulse at cyc %0d required %0d", mon_e.name, cyc, mon_e.at);
                    end
                end
            end
            last_rdy = div_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input int lat, input string name);
        opa = a;
        opb = b;
        signed_div = s;
        start = 1'b1;
        q.push_back('{res: exp, at: cyc + lat, name: name});
        last_res = exp;
        step();
        start = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (q.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending after %0d cycles, required 0", q.size(), maxc);
            q.delete();
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!div_ready && n < 60) begin
            step();
            n++;
        end
        check({name, "_ready_seen"}, 64'(div_ready), 64'd1);
    endtask

    initial begin
        int p0;
        logic [63:0] pre;

        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(div_ready), 64'd0);
        check("reset_result", result, 64'd0);
        resetn = 1'b1;
        step();

        issue(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu_100_7");
        drain(60);
        issue(32'hFFFFFF9C, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, "div_m100_7");
        drain(60);
        issue(32'd100, 32'hFFFFFFF9, 1'b1, {32'd2, 32'hFFFFFFF2}, 33, "div_100_m7");
        drain(60);
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000}, 33, "div_ovf");
        drain(60);
        issue(32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'd0}, 33, "divu_big");
        drain(60);
        issue(32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFFFFFF}, ZLAT, "divu_5_0");
        drain(60);
        issue(32'hFFFFFFF8, 32'd0, 1'b1, {32'hFFFFFFF8, 32'hFFFFFFFF}, ZLAT, "div_m8_0");
        drain(60);
        issue(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 33, "divu_max_1");
        drain(60);
        issue(32'd7, 32'd100, 1'b0, {32'd7, 32'd0}, 33, "divu_7_100");
        drain(60);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, {32'd0, 32'd1}, 33, "div_m1_m1");
        drain(60);

        pre = last_res;
        p0 = npulse;
        opa = 32'd50;
        opb = 32'd5;
        signed_div = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        annul = 1'b1;
        step();
        annul = 1'b0;
        repeat (40) step();
        check("annul_no_pulse", 64'(npulse), 64'(p0));
        check("annul_result_kept", result, pre);

        opa = 32'd12;
        opb = 32'd3;
        start = 1'b1;
        annul = 1'b1;
        step();
        start = 1'b0;
        annul = 1'b0;
        repeat (40) step();
        check("annul_start_no_pulse", 64'(npulse), 64'(p0));
        check("annul_start_result", result, pre);

        issue(32'd9, 32'd2, 1'b0, {32'd1, 32'd4}, 33, "divu_9_2");
        drain(60);

        p0 = npulse;
        opa = 32'd1000;
        opb = 32'd10;
        signed_div = 1'b0;
        start = 1'b1;
        q.push_back('{res: {32'd0, 32'd100}, at: cyc + 33, name: "b2b_first"});
        step();
        wait_ready("b2b");
        step();
        opa = 32'd81;
        opb = 32'd9;
        q.push_back('{res: {32'd0, 32'd9}, at: cyc + 33, name: "b2b_second"});
        step();
        start = 1'b0;
        drain(60);
        check("b2b_pulse_count", 64'(npulse), 64'(p0 + 2));

        opa = 32'd123;
        opb = 32'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        #2;
        resetn = 1'b0;
        #1;
        check("reset_mid_ready", 64'(div_ready), 64'd0);
        check("reset_mid_result", result, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step();

        opa = 32'd6;
        opb = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_ready("rst_done");
        #1;
        resetn = 1'b0;
        #1;
        check("reset_done_ready", 64'(div_ready), 64'd0);
        check("reset_done_result", result, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step();

        issue(32'd1000, 32'd33, 1'b0, {32'd10, 32'd30}, 33, "divu_after_reset");
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
